// File: rtl/as2650_mem_arbiter.sv
// Round-robin CPU / Wishbone-host arbiter onto one memory port: grant one cycle after req, ack one cycle after mem_ready.
// Requesters hold req until ack; `define ARB_TIMEOUT_EN adds a wait counter that aborts stalled transfers and sets arb_err.
module as2650_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              wb_req,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              wb_ack,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_TIMEOUT_EN
  output logic              arb_err,
`endif
  output logic              busy,
  output logic              grant_wb
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, CPU_XFER, WB_XFER} state_t;

  state_t state, state_nxt;
  logic   prio_wb;    // host wins the next tie (CPU was granted last)
  logic   pick_wb;
  logic   start;
  logic   finish;
  logic   timed_out;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    pick_wb   = wb_req && (!cpu_req || prio_wb);
    start     = (state == IDLE) && (cpu_req || wb_req);
    finish    = (state != IDLE) && (mem_ready || timed_out);
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = pick_wb ? WB_XFER : CPU_XFER;
      CPU_XFER: if (finish) state_nxt = IDLE;
      WB_XFER:  if (finish) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      wb_ack    <= 1'b0;
      cpu_rdata <= '0;
      wb_rdata  <= '0;
      busy      <= 1'b0;
      grant_wb  <= 1'b0;
      prio_wb   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      wb_ack  <= 1'b0;
      if (start) begin
        mem_req   <= 1'b1;
        busy      <= 1'b1;
        grant_wb  <= pick_wb;
        prio_wb   <= !pick_wb;
        mem_we    <= pick_wb ? wb_we    : cpu_we;
        mem_addr  <= pick_wb ? wb_addr  : cpu_addr;
        mem_wdata <= pick_wb ? wb_wdata : cpu_wdata;
      end else if (finish) begin
        mem_req <= 1'b0;
        busy    <= 1'b0;
        // An aborted transfer reports all-ones regardless of direction
        if (grant_wb) begin
          wb_ack <= 1'b1;
          if (timed_out)    wb_rdata <= '1;
          else if (!mem_we) wb_rdata <= mem_rdata;
        end else begin
          cpu_ack <= 1'b1;
          if (timed_out)    cpu_rdata <= '1;
          else if (!mem_we) cpu_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;

  assign timed_out = (state != IDLE) && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      arb_err  <= 1'b0;
    end else begin
      if (start)                           wait_cnt <= '0;
      else if (state != IDLE && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
      if (finish && timed_out)             arb_err  <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

endmodule
